// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared CBus types and arbiter state encoding.
package cbus_rr_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } cbus_size_t;

    // Encoded as beats-1.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } cbus_len_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2
    } cbus_burst_t;

    typedef struct packed {
        logic              valid;
        logic              is_write;
        cbus_size_t        size;
        logic [ADDR_W-1:0] addr;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
        cbus_len_t         len;
        cbus_burst_t       burst;
    } cbus_req_t;

    typedef struct packed {
        logic              ready;
        logic              last;
        logic [DATA_W-1:0] data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of valid at or after ptr, wrapping.
module rr_pick #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    // Scan N candidates starting at ptr; the first hit wins.
    always_comb begin
        int unsigned      cand;
        logic [IDX_W-1:0] cand_idx;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = 32'(ptr) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!found && valid[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// N-to-1 CBus arbiter; holds the grant for a whole burst and routes the response back.
module cbus_rr_arbiter
    import cbus_rr_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_INPUTS  = 4,
    parameter  bit          ROUND_ROBIN = 1'b1,
    localparam int unsigned IDX_W       = $clog2(NUM_INPUTS)
) (
    input  logic             clk,
    input  logic             reset,
    input  cbus_req_t        ireqs  [NUM_INPUTS],
    output cbus_resp_t       iresps [NUM_INPUTS],
    output cbus_req_t        oreq,
    input  cbus_resp_t       oresp,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx
);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       grant_q, grant_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [NUM_INPUTS-1:0]  req_valid;
    logic [IDX_W-1:0]       pick_ptr;
    logic                   pick_found;
    logic [IDX_W-1:0]       pick_idx;

    // Gather the per-port valid bits.
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

    // Fixed priority reuses the picker with the search anchored at port 0.
    assign pick_ptr = ROUND_ROBIN ? ptr_q : '0;

    rr_pick #(
        .N (NUM_INPUTS)
    ) u_pick (
        .valid (req_valid),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // State, grant and priority pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: arbitrate only while idle, release on the last accepted beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = BUSY;
                    grant_d = pick_idx;
                    if (ROUND_ROBIN) begin
                        if (32'(pick_idx) == NUM_INPUTS - 1) begin
                            ptr_d = '0;
                        end else begin
                            ptr_d = pick_idx + IDX_W'(1);
                        end
                    end
                end
            end
            BUSY: begin
                if (oresp.ready && oresp.last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath mux: pass the granted request out and its response back; quiet otherwise.
    always_comb begin
        oreq = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            iresps[i] = '0;
        end
        if (!reset && state_q == BUSY) begin
            oreq            = ireqs[grant_q];
            iresps[grant_q] = oresp;
        end
    end

    assign busy      = (state_q == BUSY);
    assign grant_idx = grant_q;

endmodule
